// File: rtl/riscv151_io_pkg.sv
// Shared definitions for the memory-mapped I/O window: register offsets and
// the UART transmit state encoding.
package riscv151_io_pkg;

    localparam logic [7:0] IO_CTRL    = 8'h00;
    localparam logic [7:0] IO_RX      = 8'h04;
    localparam logic [7:0] IO_TX      = 8'h08;
    localparam logic [7:0] IO_CYC     = 8'h10;
    localparam logic [7:0] IO_INSTR   = 8'h14;
    localparam logic [7:0] IO_CNT_RST = 8'h18;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/io_counters.sv
// Free-running cycle counter and retired-instruction counter with a shared
// synchronous clear; both wrap at 32 bits.
module io_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        instr_inc,
    output logic [31:0] cyc_cnt,
    output logic [31:0] instr_cnt
);

    logic [31:0] cyc_q, cyc_d;
    logic [31:0] instr_q, instr_d;

    // Clear has priority over the increments in the same cycle.
    always_comb begin
        cyc_d   = cyc_q + 32'd1;
        instr_d = instr_q + {31'd0, instr_inc};
        if (clr) begin
            cyc_d   = 32'd0;
            instr_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q   <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            cyc_q   <= cyc_d;
            instr_q <= instr_d;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign instr_cnt = instr_q;

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller: decodes the I/O window, sequences UART TX/RX handshakes and
// returns read data one cycle after the request, like the synchronous memories.
module mmio_uart_ctrl
    import riscv151_io_pkg::*;
#(
    parameter logic [3:0] IO_BASE_NIBBLE = 4'h8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic        instr_retired,
    output logic        io_hit,
    output logic [31:0] rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    tx_state_e   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cyc_cnt, instr_cnt;
    logic [7:0]  off;
    logic        io_wr, io_rd, tx_free;
    logic        unused_ok;

    assign io_hit = (addr[31:28] == IO_BASE_NIBBLE);
    assign off    = addr[7:0];
    assign io_wr  = io_hit && (we != 4'b0000);
    assign io_rd  = io_hit && re;

    assign uart_rx_ready = io_rd && (off == IO_RX) && uart_rx_valid;

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        uart_tx_valid = 1'b0;
        tx_free       = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_free = 1'b1;
                if (io_wr && (off == IO_TX)) begin
                    tx_data_d = wdata[7:0];
                    state_d   = TX_SEND;
                end
            end
            TX_SEND: begin
                uart_tx_valid = 1'b1;
                if (uart_tx_ready) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Reads sample pre-edge state, so a same-cycle write is not visible yet.
    always_comb begin
        rdata_d = rdata_q;
        if (io_rd) begin
            case (off)
                IO_CTRL:  rdata_d = {30'd0, uart_rx_valid, tx_free};
                IO_RX:    rdata_d = uart_rx_valid ? {24'd0, uart_rx_data} : 32'd0;
                IO_CYC:   rdata_d = cyc_cnt;
                IO_INSTR: rdata_d = instr_cnt;
                default:  rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= TX_IDLE;
            tx_data_q <= 8'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            rdata_q   <= rdata_d;
        end
    end

    io_counters u_counters (
        .clk       (clk),
        .rst       (rst),
        .clr       (io_wr && (off == IO_CNT_RST)),
        .instr_inc (instr_retired),
        .cyc_cnt   (cyc_cnt),
        .instr_cnt (instr_cnt)
    );

    assign rdata        = rdata_q;
    assign uart_tx_data = tx_data_q;

    assign unused_ok = ^{wdata[31:8], addr[27:8]};

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Self-checking bench for mmio_uart_ctrl: directed vectors, corner sequences
// and random traffic against a cycle-level behavioural model.
module tb_mmio_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  we = '0;
    logic        re = 1'b0;
    logic        instr_retired = 1'b0;
    logic        io_hit;
    logic [31:0] rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;

    int checks = 0;
    int errors = 0;

    mmio_uart_ctrl #(.IO_BASE_NIBBLE(4'h8)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .instr_retired (instr_retired),
        .io_hit        (io_hit),
        .rdata         (rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    always #5 clk = ~clk;

    // Behavioural model: what software would observe, cycle by cycle.
    logic [31:0] m_cyc, m_instr, m_rdata;
    logic        m_busy;
    logic [7:0]  m_txb;
    logic        m_hit, m_wr, m_rd;
    logic [7:0]  m_off;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc = 0; m_instr = 0; m_rdata = 0; m_busy = 0; m_txb = 0;
        end else begin
            m_hit = (addr[31:28] == 4'h8);
            m_wr  = m_hit && (we != 0);
            m_rd  = m_hit && re;
            m_off = addr[7:0];
            if (m_rd) begin
                if (m_off == 8'h00)      m_rdata = {30'd0, uart_rx_valid, !m_busy};
                else if (m_off == 8'h04) m_rdata = uart_rx_valid ? {24'd0, uart_rx_data} : 32'd0;
                else if (m_off == 8'h10) m_rdata = m_cyc;
                else if (m_off == 8'h14) m_rdata = m_instr;
                else                     m_rdata = 32'd0;
            end
            if (m_busy) begin
                if (uart_tx_ready) m_busy = 0;
            end else if (m_wr && m_off == 8'h08) begin
                m_busy = 1;
                m_txb  = wdata[7:0];
            end
            if (m_wr && m_off == 8'h18) begin
                m_cyc = 0; m_instr = 0;
            end else begin
                m_cyc   = m_cyc + 1;
                m_instr = m_instr + (instr_retired ? 1 : 0);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock: check combinational outputs before the edge, registered after.
    task automatic step();
        logic exp_hit;
        #1;
        exp_hit = (addr[31:28] == 4'h8);
        chk("io_hit", {31'd0, io_hit}, {31'd0, exp_hit});
        chk("rx_ready", {31'd0, uart_rx_ready},
            {31'd0, exp_hit && re && addr[7:0] == 8'h04 && uart_rx_valid});
        @(posedge clk);
        #1;
        chk("rdata", rdata, m_rdata);
        chk("tx_valid", {31'd0, uart_tx_valid}, {31'd0, m_busy});
        chk("tx_data", {24'd0, uart_tx_data}, {24'd0, m_txb});
    endtask

    task automatic idle();
        addr = '0; wdata = '0; we = '0; re = 0; instr_retired = 0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  rxd;
        logic        rxv;
        logic        re;
        logic        hit;
        logic        rdy;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[9];
    int   cnt;

    initial begin
        vecs[0] = '{32'h8000_0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0001};
        vecs[1] = '{32'h8000_0000, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0003};
        vecs[2] = '{32'h8000_0004, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_005A};
        vecs[3] = '{32'h8000_0004, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_005A};
        vecs[4] = '{32'h7000_0004, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_005A};
        vecs[5] = '{32'h8000_0104, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0011};
        vecs[6] = '{32'h8000_0004, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h8000_000C, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000};
        vecs[8] = '{32'hF000_0010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};

        // Reset state and cycle count after 5 idle cycles.
        #2;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
        #10 rst = 1;
        for (int i = 0; i < 5; i++) step();
        addr = 32'h8000_0010; re = 1;
        step();
        chk("cyc_after_5", rdata, 32'd5);
        addr = 32'h8000_0000;
        step();
        chk("ctrl_idle", rdata, 32'h1);

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            idle();
            addr = vecs[i].addr; re = vecs[i].re;
            uart_rx_data = vecs[i].rxd; uart_rx_valid = vecs[i].rxv;
            #1;
            chk($sformatf("vec%0d_hit", i), {31'd0, io_hit}, {31'd0, vecs[i].hit});
            chk($sformatf("vec%0d_rdy", i), {31'd0, uart_rx_ready}, {31'd0, vecs[i].rdy});
            step();
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
        end

        // TX with ready held low 3 cycles, second store dropped.
        idle(); uart_rx_valid = 0; uart_tx_ready = 0;
        addr = 32'h8000_0008; wdata = 32'hFFFF_FF41; we = 4'h1;
        #1 chk("tx_valid_pre", {31'd0, uart_tx_valid}, 32'd0);
        step();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (uart_tx_valid) begin
                cnt++;
                chk("tx_byte", {24'd0, uart_tx_data}, 32'h41);
            end
            idle();
            uart_tx_ready = (i == 3);
            if (i == 0) begin addr = 32'h8000_0000; re = 1; end
            if (i == 1) begin addr = 32'h8000_0008; wdata = 32'h42; we = 4'hF; end
            step();
            if (i == 0) chk("ctrl_busy", rdata, 32'h0);
        end
        chk("tx_valid_cycles", cnt, 32'd4);
        uart_tx_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tx_no_resend", {31'd0, uart_tx_valid}, 32'd0);
        end
        chk("tx_data_kept", {24'd0, uart_tx_data}, 32'h41);

        // Counter clear colliding with an instruction retirement.
        idle(); addr = 32'h8000_0018; we = 4'h1; step();
        for (int i = 0; i < 6; i++) begin
            idle(); instr_retired = 1;
            if (i == 5) begin addr = 32'h8000_0014; re = 1; end
            step();
        end
        chk("instr_6", rdata, 32'd5);
        idle(); instr_retired = 1; addr = 32'h8000_0018; we = 4'h8; step();
        idle(); addr = 32'h8000_0010; re = 1; step();
        chk("cyc_cleared", rdata, 32'd0);
        addr = 32'h8000_0014; step();
        chk("instr_cleared", rdata, 32'd0);

        // Cycle counter wrap.
        idle();
        force dut.u_counters.cyc_q = 32'hFFFF_FFFF;
        #1 release dut.u_counters.cyc_q;
        m_cyc = 32'hFFFF_FFFF;
        addr = 32'h8000_0010; re = 1;
        step();
        chk("cyc_max", rdata, 32'hFFFF_FFFF);
        step();
        chk("cyc_wrap", rdata, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] offs [8];
            offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
            addr = {($urandom_range(0, 6) == 0) ? 4'h3 : 4'h8, 20'($urandom), offs[$urandom_range(0, 7)]};
            wdata = $urandom;
            we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            if (addr[7:0] == 8'h18 && $urandom_range(0, 3) != 0) we = 4'h0;
            re = $urandom_range(0, 1);
            instr_retired = $urandom_range(0, 1);
            uart_tx_ready = ($urandom_range(0, 2) == 0);
            uart_rx_valid = $urandom_range(0, 1);
            uart_rx_data = 8'($urandom);
            step();
        end

        // Asynchronous reset in the middle of SEND.
        idle(); uart_tx_ready = 0; uart_rx_valid = 1;
        addr = 32'h8000_0008; wdata = 32'hC3; we = 4'h1;
        step();
        chk("send_before_rst", {31'd0, uart_tx_valid}, 32'd1);
        idle(); addr = 32'h8000_0004; re = 1; step();
        idle();
        #2 rst = 0;
        #1;
        chk("rst_async_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        chk("rst_async_tx_data", {24'd0, uart_tx_data}, 32'd0);
        chk("rst_async_rdata", rdata, 32'd0);
        chk("rst_async_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
        #2 rst = 1;
        uart_rx_valid = 0;
        addr = 32'h8000_0010; re = 1;
        step();
        chk("cyc_after_rst", rdata, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
